// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM-sequenced main decoder with NZCV flags and condition gating
// for a shared-memory ARM-subset datapath, with optional wait-stated memory handshake.
module multicycle_controller #(
  parameter int unsigned ALU_OP_W = 3,
  parameter bit ENABLE_SHIFT = 1'b1,
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cond,
  input  logic [1:0]          op,
  input  logic [5:0]          funct,
  input  logic [3:0]          ALU_flags,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_A2src,
  output logic                imm_src,
  output logic                alu_srcA,
  output logic [1:0]          alu_srcB,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                shift_dir,
  output logic                aluorshft,
  output logic [1:0]          result_src,
  output logic                illegal
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_EXECS = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10;
  logic [3:0] state_q, state_d, flags_q, flags_d;
  logic       ce_q, ce_d, cond_ex, rdy, is_cmp, cmd_ok, bad, upd, arith;
  logic [3:0] cmd;
  logic [1:0] alu_c;
  logic       pcw, irw, adr, mw, rw, a2, imm, sa, sd, aos, ill;
  logic [1:0] sb, rs, aop;
  assign rdy    = MEM_WAIT ? mem_ready : 1'b1;
  assign cmd    = funct[4:1];
  assign is_cmp = (op == 2'b00) && (cmd == 4'b1010);
  assign cmd_ok = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b1010;
  assign bad    = (op == 2'b00 && !cmd_ok) || (op == 2'b11 && !ENABLE_SHIFT);
  assign alu_c  = cmd == 4'b0100 ? 2'd0 : (cmd == 4'b0010 || cmd == 4'b1010) ? 2'd1 :
                  cmd == 4'b0000 ? 2'd2 : 2'd3;
  assign arith  = (op == 2'b00) && !alu_c[1];
  always_comb begin
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = flags_q[3] == flags_q[0];
      4'b1011: cond_ex = flags_q[3] != flags_q[0];
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // Condition is captured at DECODE so a flag-setting instruction is gated by pre-update flags
  assign ce_d = (state_q == S_DECODE) ? cond_ex : ce_q;
  // Shifts carry no S bit (funct[0] is direction), so they always update N,Z when executed
  assign upd = ce_q && (state_q == S_EXECS ||
               ((state_q == S_EXECR || state_q == S_EXECI) && (funct[0] || is_cmp)));
  assign flags_d = !upd ? flags_q : arith ? ALU_flags : {ALU_flags[3:2], flags_q[1:0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = bad ? S_FETCH : op == 2'b01 ? S_MEMADR : op == 2'b10 ? S_BRANCH :
                            op == 2'b11 ? S_EXECS : funct[5] ? S_EXECI : S_EXECR;
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_EXECS: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end
  always_comb begin
    {pcw, irw, adr, mw, rw, a2, imm, sa, sd, aos, ill} = '0;
    sb  = 2'd0;
    rs  = 2'd0;
    aop = 2'd0;
    case (state_q)
      S_FETCH:    begin irw = rdy; pcw = rdy; sa = 1'b1; sb = 2'd2; rs = 2'd2; end
      S_DECODE:   begin sa = 1'b1; sb = 2'd2; ill = bad; end
      S_MEMADR:   begin sb = 2'd1; a2 = ~funct[0]; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin rs = 2'd1; rw = ce_q; end
      S_MEMWRITE: begin adr = 1'b1; a2 = 1'b1; mw = ce_q; end
      S_EXECR:    aop = alu_c;
      S_EXECI:    begin sb = 2'd1; aop = alu_c; end
      S_EXECS:    begin aos = 1'b1; sd = funct[0]; end
      S_ALUWB:    begin rw = ce_q & ~is_cmp; aos = op == 2'b11; end
      S_BRANCH:   begin sb = 2'd1; imm = 1'b1; rs = 2'd2; pcw = ce_q; end
      default:    ;
    endcase
  end
  assign pc_write   = rst_n & pcw;
  assign ir_write   = rst_n & irw;
  assign adr_src    = rst_n & adr;
  assign mem_write  = rst_n & mw;
  assign reg_write  = rst_n & rw;
  assign reg_A2src  = rst_n & a2;
  assign imm_src    = rst_n & imm;
  assign alu_srcA   = rst_n & sa;
  assign alu_srcB   = {2{rst_n}} & sb;
  assign alu_op     = {ALU_OP_W{rst_n}} & {{(ALU_OP_W-2){1'b0}}, aop};
  assign shift_dir  = rst_n & sd;
  assign aluorshft  = rst_n & aos;
  assign result_src = {2{rst_n}} & rs;
  assign illegal    = rst_n & ill;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ce_q    <= ce_d;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle controller, 1-cycle memory
// instance first, then a wait-stated instance without shift support.
module tb_multicycle_controller;
  logic clk, rst_n, mem_ready, sel;
  logic [3:0] cond, ALU_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic pw0, iw0, as0, mw0, rw0, a20, is0, sa0, sd0, ao0, il0;
  logic pw1, iw1, as1, mw1, rw1, a21, is1, sa1, sd1, ao1, il1;
  logic [1:0] sb0, rs0, sb1, rs1;
  logic [2:0] op0, op1;
  logic [17:0] o0, o1;
  logic [17:0] F, FS, D, DI, BR1, BR0, WB1, WB0, MAS, MAL, MRD, MWB, MWR1, MWR0, EXS, WBS, Z;
  int total = 0, bad = 0;
  multicycle_controller dut0 (.clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct),
    .ALU_flags(ALU_flags), .mem_ready(mem_ready), .pc_write(pw0), .ir_write(iw0), .adr_src(as0),
    .mem_write(mw0), .reg_write(rw0), .reg_A2src(a20), .imm_src(is0), .alu_srcA(sa0),
    .alu_srcB(sb0), .alu_op(op0), .shift_dir(sd0), .aluorshft(ao0), .result_src(rs0), .illegal(il0));
  multicycle_controller #(.ALU_OP_W(3), .ENABLE_SHIFT(1'b0), .MEM_WAIT(1'b1)) dut1 (.clk(clk),
    .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .ALU_flags(ALU_flags), .mem_ready(mem_ready),
    .pc_write(pw1), .ir_write(iw1), .adr_src(as1), .mem_write(mw1), .reg_write(rw1),
    .reg_A2src(a21), .imm_src(is1), .alu_srcA(sa1), .alu_srcB(sb1), .alu_op(op1), .shift_dir(sd1),
    .aluorshft(ao1), .result_src(rs1), .illegal(il1));
  assign o0 = {pw0, iw0, as0, mw0, rw0, a20, is0, sa0, sb0, op0, sd0, ao0, rs0, il0};
  assign o1 = {pw1, iw1, as1, mw1, rw1, a21, is1, sa1, sb1, op1, sd1, ao1, rs1, il1};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [17:0] v(input logic pcw, irw, adr, mw, rw, a2, imm, sa,
      input logic [1:0] sb, input logic [2:0] aop, input logic sd, aos, input logic [1:0] rs,
      input logic ill);
    return {pcw, irw, adr, mw, rw, a2, imm, sa, sb, aop, sd, aos, rs, ill};
  endfunction
  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, sel ? o1 : o0, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
      input logic [3:0] af);
    cond = c;
    op = o;
    funct = f;
    ALU_flags = af;
  endtask
  task automatic br(input string tag, input logic [3:0] c, input logic taken);
    instr(c, 2'b10, 6'b000000, 4'b0000);
    step({tag, "_fetch"}, F);
    step({tag, "_decode"}, D);
    step(tag, taken ? BR1 : BR0);
  endtask
  initial begin
    F    = v(1,1,0,0,0,0,0,1,2'd2,3'd0,0,0,2'd2,0);
    FS   = v(0,0,0,0,0,0,0,1,2'd2,3'd0,0,0,2'd2,0);
    D    = v(0,0,0,0,0,0,0,1,2'd2,3'd0,0,0,2'd0,0);
    DI   = v(0,0,0,0,0,0,0,1,2'd2,3'd0,0,0,2'd0,1);
    BR1  = v(1,0,0,0,0,0,1,0,2'd1,3'd0,0,0,2'd2,0);
    BR0  = v(0,0,0,0,0,0,1,0,2'd1,3'd0,0,0,2'd2,0);
    WB1  = v(0,0,0,0,1,0,0,0,2'd0,3'd0,0,0,2'd0,0);
    WB0  = '0;
    MAS  = v(0,0,0,0,0,1,0,0,2'd1,3'd0,0,0,2'd0,0);
    MAL  = v(0,0,0,0,0,0,0,0,2'd1,3'd0,0,0,2'd0,0);
    MRD  = v(0,0,1,0,0,0,0,0,2'd0,3'd0,0,0,2'd0,0);
    MWB  = v(0,0,0,0,1,0,0,0,2'd0,3'd0,0,0,2'd1,0);
    MWR1 = v(0,0,1,1,0,1,0,0,2'd0,3'd0,0,0,2'd0,0);
    MWR0 = v(0,0,1,0,0,1,0,0,2'd0,3'd0,0,0,2'd0,0);
    EXS  = v(0,0,0,0,0,0,0,0,2'd0,3'd0,1,1,2'd0,0);
    WBS  = v(0,0,0,0,1,0,0,0,2'd0,3'd0,0,1,2'd0,0);
    Z    = '0;
    sel = 1'b0;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instr(4'b1110, 2'b00, 6'b001000, 4'b0000);
    #1;
    chk("reset_out0", o0, Z);
    chk("reset_out1", o1, Z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // ADD register, no S
    step("add_fetch", F);
    step("add_decode", D);
    step("add_execr", v(0,0,0,0,0,0,0,0,2'd0,3'd0,0,0,2'd0,0));
    step("add_aluwb", WB1);
    // SUBS sets Z, then EQ taken / NE not taken
    instr(4'b1110, 2'b00, 6'b000101, 4'b0100);
    step("subs_fetch", F);
    step("subs_decode", D);
    step("subs_execr", v(0,0,0,0,0,0,0,0,2'd0,3'd1,0,0,2'd0,0));
    step("subs_aluwb", WB1);
    br("beq_z1", 4'b0000, 1'b1);
    br("bne_z1", 4'b0001, 1'b0);
    // ADDS immediate loads 0011, then ANDS with 1000 keeps C,V -> 1011
    instr(4'b1110, 2'b00, 6'b101001, 4'b0011);
    step("addsi_fetch", F);
    step("addsi_decode", D);
    step("addsi_execi", v(0,0,0,0,0,0,0,0,2'd1,3'd0,0,0,2'd0,0));
    step("addsi_aluwb", WB1);
    instr(4'b1110, 2'b00, 6'b000001, 4'b1000);
    step("ands_fetch", F);
    step("ands_decode", D);
    step("ands_execr", v(0,0,0,0,0,0,0,0,2'd0,3'd2,0,0,2'd0,0));
    step("ands_aluwb", WB1);
    br("bcs_c_kept", 4'b0010, 1'b1);
    br("bvs_v_kept", 4'b0110, 1'b1);
    br("bmi_n_set", 4'b0100, 1'b1);
    br("beq_z_clr", 4'b0000, 1'b0);
    // CMP with S bit clear still sets flags, never writes register
    instr(4'b1110, 2'b00, 6'b010100, 4'b0100);
    step("cmp_fetch", F);
    step("cmp_decode", D);
    step("cmp_execr", v(0,0,0,0,0,0,0,0,2'd0,3'd1,0,0,2'd0,0));
    step("cmp_aluwb", WB0);
    br("beq_after_cmp", 4'b0000, 1'b1);
    // ADDSNE with Z=1 is suppressed: no write, flags untouched
    instr(4'b0001, 2'b00, 6'b001001, 4'b0000);
    step("addne_fetch", F);
    step("addne_decode", D);
    step("addne_execr", v(0,0,0,0,0,0,0,0,2'd0,3'd0,0,0,2'd0,0));
    step("addne_aluwb", WB0);
    br("beq_after_supp", 4'b0000, 1'b1);
    instr(4'b1110, 2'b01, 6'b000000, 4'b0000);
    step("str_fetch", F);
    step("str_decode", D);
    step("str_memadr", MAS);
    step("str_memwrite", MWR1);
    instr(4'b1110, 2'b01, 6'b000001, 4'b0000);
    step("ldr_fetch", F);
    step("ldr_decode", D);
    step("ldr_memadr", MAL);
    step("ldr_memread", MRD);
    step("ldr_memwb", MWB);
    instr(4'b1111, 2'b01, 6'b000000, 4'b0000);
    step("strnv_fetch", F);
    step("strnv_decode", D);
    step("strnv_memadr", MAS);
    step("strnv_memwrite", MWR0);
    instr(4'b1110, 2'b00, 6'b011110, 4'b0000);
    step("ill_fetch", F);
    step("ill_decode", DI);
    // Shift right: N,Z from shifter (1,0), C,V kept from CMP (0,0)
    instr(4'b1110, 2'b11, 6'b000001, 4'b1000);
    step("ill_then_fetch", F);
    step("shr_decode", D);
    step("shr_execs", EXS);
    step("shr_aluwb", WBS);
    br("bmi_after_shift", 4'b0100, 1'b1);
    instr(4'b1110, 2'b01, 6'b000000, 4'b0000);
    step("rstw_fetch", F);
    step("rstw_decode", D);
    step("rstw_memadr", MAS);
    #1;
    chk("rstw_memwrite", o0, MWR1);
    rst_n = 1'b0;
    #1;
    chk("rstw_forced0", o0, Z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    br("bpl_flags_cleared", 4'b0101, 1'b1);
    // Wait-stated instance: stalls in FETCH, MEMREAD, MEMWRITE; op=11 illegal
    rst_n = 1'b0;
    #1;
    chk("mw_reset_out", o1, Z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = 1'b1;
    mem_ready = 1'b0;
    instr(4'b1110, 2'b01, 6'b000001, 4'b0000);
    step("mw_fetch_stall1", FS);
    step("mw_fetch_stall2", FS);
    mem_ready = 1'b1;
    step("mw_fetch_ready", F);
    mem_ready = 1'b0;
    step("mw_ldr_decode", D);
    step("mw_ldr_memadr", MAL);
    step("mw_memread_stall1", MRD);
    step("mw_memread_stall2", MRD);
    step("mw_memread_stall3", MRD);
    mem_ready = 1'b1;
    step("mw_memread_ready", MRD);
    step("mw_ldr_memwb", MWB);
    instr(4'b1110, 2'b01, 6'b000000, 4'b0000);
    step("mw_str_fetch", F);
    step("mw_str_decode", D);
    step("mw_str_memadr", MAS);
    mem_ready = 1'b0;
    step("mw_memwrite_stall1", MWR1);
    step("mw_memwrite_stall2", MWR1);
    mem_ready = 1'b1;
    step("mw_memwrite_ready", MWR1);
    instr(4'b1110, 2'b11, 6'b000000, 4'b0000);
    step("mw_shift_fetch", F);
    step("mw_shift_illegal", DI);
    step("mw_after_illegal", F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
